// File: rtl/core_trace_checker_if.sv
// Trace checker input bus: golden-trace load port plus the Core debug
// write-back port. The Core/bench side is master, the checker is slave.
interface core_trace_checker_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) ();
    logic                      load_valid;
    logic [DATA_WIDTH-1:0]     load_pc;
    logic [REG_ADDR_WIDTH-1:0] load_reg_addr;
    logic [DATA_WIDTH-1:0]     load_data;
    logic                      debug_reg_write_en;
    logic [REG_ADDR_WIDTH-1:0] debug_reg_write_addr;
    logic [DATA_WIDTH-1:0]     debug_reg_write_data;
    logic [DATA_WIDTH-1:0]     debug_pc_addr;

    modport master (
        output load_valid, load_pc, load_reg_addr, load_data,
        output debug_reg_write_en, debug_reg_write_addr,
        output debug_reg_write_data, debug_pc_addr
    );

    modport slave (
        input load_valid, load_pc, load_reg_addr, load_data,
        input debug_reg_write_en, debug_reg_write_addr,
        input debug_reg_write_data, debug_pc_addr
    );
endinterface

// File: rtl/core_trace_checker.sv
// Commit-trace checker: compares Core write-backs against a golden trace.
// Define TRACE_PC_CHECK_EN to also store and compare the commit PC.
module core_trace_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TRACE_DEPTH    = 64,
    parameter int PTR_WIDTH      = 7,
    parameter int TICK_WIDTH     = 32,
    parameter int MAX_TICKS      = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    core_trace_checker_if.slave   bus,
    input  logic                  start,
    input  logic                  clear,
    output logic [2:0]            state,
    output logic                  done,
    output logic [PTR_WIDTH-1:0]  trace_len,
    output logic [PTR_WIDTH-1:0]  match_count,
    output logic [TICK_WIDTH-1:0] tick_count,
    output logic                  load_overflow,
    output logic [PTR_WIDTH-1:0]  fail_index,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual
);
    localparam int AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t st, st_nx;

    logic [REG_ADDR_WIDTH-1:0] mem_addr [TRACE_DEPTH];
    logic [DATA_WIDTH-1:0]     mem_data [TRACE_DEPTH];

    logic                  full, load_ok, commit, data_ok, pc_ok, hit;
    logic                  last_tick;
    logic [AW-1:0]         rd_idx, wr_idx;
    logic [PTR_WIDTH-1:0]  len_eff, mc_inc;
    logic [DATA_WIDTH-1:0] fexp_nx, fact_nx;

    assign full    = trace_len == PTR_WIDTH'(TRACE_DEPTH);
    assign load_ok = (st == S_IDLE) && bus.load_valid && !full;
    assign len_eff = trace_len + PTR_WIDTH'(load_ok);
    assign mc_inc  = match_count + PTR_WIDTH'(1);
    assign rd_idx  = match_count[AW-1:0];
    assign wr_idx  = trace_len[AW-1:0];
    assign commit  = bus.debug_reg_write_en &&
                     (bus.debug_reg_write_addr != '0);
    assign data_ok = (bus.debug_reg_write_addr == mem_addr[rd_idx]) &&
                     (bus.debug_reg_write_data == mem_data[rd_idx]);
    assign hit       = data_ok && pc_ok;
    assign last_tick = tick_count == TICK_WIDTH'(MAX_TICKS - 1);

`ifdef TRACE_PC_CHECK_EN
    logic [DATA_WIDTH-1:0] mem_pc [TRACE_DEPTH];

    always_ff @(posedge clk) begin
        if (load_ok) mem_pc[wr_idx] <= bus.load_pc;
    end

    assign pc_ok = bus.debug_pc_addr == mem_pc[rd_idx];

    // A PC-only miss reports the PCs; any data/address miss reports data.
    always_comb begin
        fexp_nx = mem_data[rd_idx];
        fact_nx = bus.debug_reg_write_data;
        if (data_ok && !pc_ok) begin
            fexp_nx = mem_pc[rd_idx];
            fact_nx = bus.debug_pc_addr;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{bus.load_pc, bus.debug_pc_addr};
    assign pc_ok     = 1'b1;
    assign fexp_nx   = mem_data[rd_idx];
    assign fact_nx   = bus.debug_reg_write_data;
`endif

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_addr[wr_idx] <= bus.load_reg_addr;
            mem_data[wr_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st <= S_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            S_IDLE: begin
                if (start) st_nx = (len_eff == '0) ? S_PASS : S_RUN;
            end
            S_RUN: begin
                if (commit && !hit)                   st_nx = S_FAIL;
                else if (commit && mc_inc == trace_len) st_nx = S_PASS;
                else if (last_tick)                   st_nx = S_TIMEOUT;
            end
            S_PASS, S_FAIL, S_TIMEOUT: begin
                if (clear) st_nx = S_IDLE;
            end
            default: st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_len     <= '0;
            match_count   <= '0;
            tick_count    <= '0;
            load_overflow <= 1'b0;
            fail_index    <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
        end else begin
            if (load_ok) trace_len <= len_eff;
            if (st == S_IDLE && bus.load_valid && full)
                load_overflow <= 1'b1;
            if (st == S_IDLE && start) begin
                match_count   <= '0;
                tick_count    <= '0;
                fail_index    <= '0;
                fail_expected <= '0;
                fail_actual   <= '0;
            end
            if (st == S_RUN) begin
                // The count freezes on the cycle that decides the verdict.
                if (st_nx == S_RUN) tick_count <= tick_count + TICK_WIDTH'(1);
                if (commit && hit) match_count <= mc_inc;
                if (commit && !hit) begin
                    fail_index    <= match_count;
                    fail_expected <= fexp_nx;
                    fail_actual   <= fact_nx;
                end
            end
        end
    end

    assign state = st;
    assign done  = (st == S_PASS) || (st == S_FAIL) || (st == S_TIMEOUT);
endmodule

// File: tb/tb_core_trace_checker.sv
// Scoreboard bench for core_trace_checker: a cycle-walk reference model
// predicts each run's verdict, a monitor compares on every rising done.
module tb_core_trace_checker;
    localparam int MAXT = 15;
    localparam int NEV  = 64;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    typedef struct {
        logic [2:0]  st;
        int          mc;
        int          tk;
        int          fi;
        logic [31:0] fe;
        logic [31:0] fa;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear;
    logic [2:0]  state;
    logic        done;
    logic [6:0]  trace_len, match_count, fail_index;
    logic [31:0] tick_count, fail_expected, fail_actual;
    logic        load_overflow;

    core_trace_checker_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    core_trace_checker #(.MAX_TICKS(MAXT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .start         (start),
        .clear         (clear),
        .state         (state),
        .done          (done),
        .trace_len     (trace_len),
        .match_count   (match_count),
        .tick_count    (tick_count),
        .load_overflow (load_overflow),
        .fail_index    (fail_index),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t        tr[$];
    exp_t        sbq[$];
    exp_t        last;
    logic        ev_en [NEV];
    logic [4:0]  ev_a  [NEV];
    logic [31:0] ev_d  [NEV];
    logic [31:0] ev_p  [NEV];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Walk the RUN cycles applying the checker rules to the event list.
    function automatic exp_t model();
        exp_t r;
        int   m = 0;
        r.st = 3'd2; r.mc = 0; r.tk = 0; r.fi = 0; r.fe = '0; r.fa = '0;
        if (tr.size() == 0) return r;
        for (int c = 0; c < MAXT; c++) begin
            if (ev_en[c] && ev_a[c] != 5'd0) begin
                bit dok, pok;
                dok = (ev_a[c] == tr[m].a) && (ev_d[c] == tr[m].d);
                pok = 1'b1;
`ifdef TRACE_PC_CHECK_EN
                pok = ev_p[c] == tr[m].p;
`endif
                if (!(dok && pok)) begin
                    r.st = 3'd3; r.mc = m; r.tk = c; r.fi = m;
                    if (dok) begin r.fe = tr[m].p; r.fa = ev_p[c]; end
                    else begin r.fe = tr[m].d; r.fa = ev_d[c]; end
                    return r;
                end
                m++;
                if (m == tr.size()) begin
                    r.st = 3'd2; r.mc = m; r.tk = c;
                    return r;
                end
            end
            if (c == MAXT - 1) begin
                r.st = 3'd4; r.mc = m; r.tk = c;
                return r;
            end
        end
        return r;
    endfunction

    initial begin : monitor
        bit pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !pd) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_verdict state=%0d", state);
                end else begin
                    e = sbq.pop_front();
                    chk("verdict_state", 64'(state), 64'(e.st));
                    chk("verdict_match", 64'(match_count), 64'(e.mc));
                    chk("verdict_tick", 64'(tick_count), 64'(e.tk));
                    chk("verdict_fidx", 64'(fail_index), 64'(e.fi));
                    chk("verdict_fexp", 64'(fail_expected), 64'(e.fe));
                    chk("verdict_fact", 64'(fail_actual), 64'(e.fa));
                end
            end
            pd = (done === 1'b1);
        end
    end

    task automatic idle_bus();
        bus.load_valid = 0; bus.load_pc = '0;
        bus.load_reg_addr = '0; bus.load_data = '0;
        bus.debug_reg_write_en = 0; bus.debug_reg_write_addr = '0;
        bus.debug_reg_write_data = '0; bus.debug_pc_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; clear = 0;
        idle_bus();
        @(negedge clk); @(negedge clk);
        rst = 0;
        tr.delete();
    endtask

    task automatic load1(input ent_t e);
        bus.load_valid = 1; bus.load_reg_addr = e.a;
        bus.load_data = e.d; bus.load_pc = e.p;
        if (tr.size() < 64) tr.push_back(e);
        @(negedge clk);
        bus.load_valid = 0;
    endtask

    task automatic clear_ev();
        for (int c = 0; c < NEV; c++) begin
            ev_en[c] = 0; ev_a[c] = '0; ev_d[c] = '0; ev_p[c] = '0;
        end
    endtask

    task automatic set_ev(input int c, input logic en, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] p);
        ev_en[c] = en; ev_a[c] = a; ev_d[c] = d; ev_p[c] = p;
    endtask

    task automatic rand_ev();
        int k = 0;
        clear_ev();
        for (int c = 0; c < MAXT; c++) begin
            int r = $urandom_range(0, 11);
            if (r < 2 || k >= tr.size())
                set_ev(c, 0, 5'($urandom), $urandom, $urandom);
            else if (r == 2)
                set_ev(c, 1, 5'd0, $urandom, $urandom);
            else if (r == 3)
                set_ev(c, 1, tr[k].a, tr[k].d ^ (32'd1 << $urandom_range(0, 31)),
                       tr[k].p);
            else if (r == 4)
                set_ev(c, 1, tr[k].a, tr[k].d, tr[k].p + 32'd4);
            else begin
                set_ev(c, 1, tr[k].a, tr[k].d, tr[k].p);
                k++;
            end
        end
    endtask

    // Start a run (optionally with a same-cycle load), drive the events,
    // then confirm the verdict and frozen counters hold.
    task automatic do_run(input bit co, input ent_t ce);
        int w = 0;
        if (co && tr.size() < 64) tr.push_back(ce);
        last = model();
        sbq.push_back(last);
        if (co) begin
            bus.load_valid = 1; bus.load_reg_addr = ce.a;
            bus.load_data = ce.d; bus.load_pc = ce.p;
        end
        start = 1;
        @(negedge clk);
        start = 0; bus.load_valid = 0;
        for (int c = 0; c < MAXT + 4; c++) begin
            if (c < MAXT) begin
                bus.debug_reg_write_en = ev_en[c];
                bus.debug_reg_write_addr = ev_a[c];
                bus.debug_reg_write_data = ev_d[c];
                bus.debug_pc_addr = ev_p[c];
            end else begin
                bus.debug_reg_write_en = 1;
                bus.debug_reg_write_addr = 5'($urandom_range(1, 31));
                bus.debug_reg_write_data = $urandom;
                bus.debug_pc_addr = $urandom;
            end
            @(negedge clk);
        end
        bus.debug_reg_write_en = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL verdict_wait pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
        chk("sticky_state", 64'(state), 64'(last.st));
        chk("sticky_match", 64'(match_count), 64'(last.mc));
        chk("sticky_tick", 64'(tick_count), 64'(last.tk));
    endtask

    task automatic do_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("clear_state", 64'(state), 64'd0);
        chk("clear_done", 64'(done), 64'd0);
    endtask

    task automatic load_abc();
        ent_t e;
        for (int i = 1; i <= 3; i++) begin
            e.a = 5'(i); e.d = 32'(i); e.p = 32'(4 * i);
            load1(e);
        end
    endtask

    initial begin
        ent_t e;
        e = '{a: 5'd0, d: 32'd0, p: 32'd0};
        do_reset();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_len", 64'(trace_len), 64'd0);
        chk("rst_match", 64'(match_count), 64'd0);
        chk("rst_tick", 64'(tick_count), 64'd0);
        chk("rst_ovf", 64'(load_overflow), 64'd0);
        chk("rst_fail", 64'({fail_index, fail_expected, fail_actual}), 64'd0);

        // Empty trace passes straight away.
        clear_ev();
        do_run(0, e);
        do_clear();

        // Matching commits on ticks 2/5/7.
        load_abc();
        chk("len3", 64'(trace_len), 64'd3);
        clear_ev();
        set_ev(2, 1, 5'd1, 32'd1, 32'd4);
        set_ev(5, 1, 5'd2, 32'd2, 32'd8);
        set_ev(7, 1, 5'd3, 32'd3, 32'd12);
        do_run(0, e);
        chk("pass_done", 64'(done), 64'd1);
        do_clear();

        // Data mismatch on the second entry, later commit ignored.
        set_ev(5, 1, 5'd2, 32'd5, 32'd8);
        do_run(0, e);
        chk("fail_idx1", 64'(fail_index), 64'd1);
        chk("fail_exp2", 64'(fail_expected), 64'd2);
        chk("fail_act5", 64'(fail_actual), 64'd5);
        do_clear();

        // Interleaved r0 writes and idle cycles.
        clear_ev();
        set_ev(0, 1, 5'd0, 32'hdead, 32'd0);
        set_ev(1, 1, 5'd1, 32'd1, 32'd4);
        set_ev(2, 0, 5'd2, 32'd9, 32'd8);
        set_ev(3, 1, 5'd0, 32'd7, 32'd8);
        set_ev(4, 1, 5'd2, 32'd2, 32'd8);
        set_ev(6, 1, 5'd0, 32'd0, 32'd0);
        set_ev(8, 1, 5'd3, 32'd3, 32'd12);
        do_run(0, e);
        do_clear();

        // Correct data, wrong PC on the third commit.
        clear_ev();
        set_ev(1, 1, 5'd1, 32'd1, 32'd4);
        set_ev(2, 1, 5'd2, 32'd2, 32'd8);
        set_ev(3, 1, 5'd3, 32'd3, 32'h10);
        do_run(0, e);
        do_clear();

        // Timeout with no commits, then a match on the last tick.
        do_reset();
        e = '{a: 5'd7, d: 32'h77, p: 32'h40};
        load1(e);
        clear_ev();
        do_run(0, e);
        chk("timeout_state", 64'(state), 64'd4);
        chk("timeout_tick", 64'(tick_count), 64'd14);
        do_clear();
        set_ev(MAXT - 1, 1, 5'd7, 32'h77, 32'h40);
        do_run(0, e);
        chk("lasttick_pass", 64'(state), 64'd2);
        do_clear();

        // Load and start in the same cycle.
        do_reset();
        e = '{a: 5'd4, d: 32'h44, p: 32'h10};
        load1(e);
        clear_ev();
        set_ev(3, 1, 5'd4, 32'h44, 32'h10);
        set_ev(6, 1, 5'd9, 32'h99, 32'h14);
        do_run(1, '{a: 5'd9, d: 32'h99, p: 32'h14});
        chk("ls_len", 64'(trace_len), 64'd2);
        do_clear();

        // Overflow, then a rerun after clear without reloading.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            e = '{a: 5'(1 + i % 31), d: 32'(i * 3), p: 32'(4 * i)};
            load1(e);
        end
        chk("ovf_len", 64'(trace_len), 64'd64);
        chk("ovf_flag", 64'(load_overflow), 64'd1);
        rand_ev();
        do_run(0, e);
        do_clear();
        chk("keep_len", 64'(trace_len), 64'd64);
        do_run(0, e);
        do_clear();

        // Reset in the middle of a run.
        do_reset();
        load_abc();
        start = 1;
        @(negedge clk);
        start = 0;
        bus.debug_reg_write_en = 1; bus.debug_reg_write_addr = 5'd1;
        bus.debug_reg_write_data = 32'd1; bus.debug_pc_addr = 32'd4;
        @(negedge clk);
        bus.debug_reg_write_en = 0;
        @(negedge clk);
        chk("mid_match", 64'(match_count), 64'd1);
        do_reset();
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_len", 64'(trace_len), 64'd0);
        chk("midrst_match", 64'(match_count), 64'd0);
        chk("midrst_tick", 64'(tick_count), 64'd0);

        // Randomised traces and commit streams.
        for (int it = 0; it < 60; it++) begin
            int n = $urandom_range(1, 5);
            do_reset();
            for (int i = 0; i < n; i++) begin
                e = '{a: 5'($urandom_range(1, 31)), d: 32'($urandom_range(0, 255)),
                      p: 32'(4 * i + 32'h100)};
                load1(e);
            end
            rand_ev();
            do_run(0, e);
            if (it % 4 == 0) begin
                do_clear();
                do_run(0, e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
